// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller: FSM states, PC step size and
// the word-address width helper used to size the loader pointer.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Bits needed to index a memory of 'depth' words (at least one bit).
    function automatic int word_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Loader, pipeline-control and instruction-memory signals of the fetch
// controller. The controller uses the slave view; its environment uses master.
interface fetch_controller_if;

    logic        load_valid;
    logic [31:0] load_data;
    logic        load_done;
    logic        load_ready;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;

    logic [31:0] pc;
    logic        pc_valid;
    logic        fault;

    modport master (
        output load_valid, load_data, load_done,
        output stall, redirect_valid, redirect_pc, halt,
        input  load_ready, imem_addr, imem_we, imem_wdata,
        input  pc, pc_valid, fault
    );

    modport slave (
        input  load_valid, load_data, load_done,
        input  stall, redirect_valid, redirect_pc, halt,
        output load_ready, imem_addr, imem_we, imem_wdata,
        output pc, pc_valid, fault
    );

endinterface

// File: rtl/fetch_controller_pc_next_sel.sv
// Next-PC selection while running: applies halt > redirect > stall > step
// priority and flags targets that fall outside the loaded instruction memory.
module fetch_controller_pc_next_sel
    import fetch_controller_pkg::*;
#(
    parameter int INSTR_DEPTH = 1024
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] next_pc,
    output logic        go_halt,
    output logic        set_fault
);

    // Byte size of the memory; 33 bits so the top word plus one step never wraps.
    localparam logic [32:0] MEM_BYTES = 33'(INSTR_DEPTH) << 2;

    logic [32:0] inc_wide;
    logic        redirect_bad;
    logic        inc_over;

    assign inc_wide     = {1'b0, pc} + 33'(PC_STEP);
    assign inc_over     = (inc_wide >= MEM_BYTES);
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= MEM_BYTES);

    // Priority chain; any fault or halt keeps the current PC.
    always_comb begin
        next_pc   = pc;
        go_halt   = 1'b0;
        set_fault = 1'b0;
        if (halt) begin
            go_halt = 1'b1;
        end else if (redirect_valid) begin
            if (redirect_bad) begin
                go_halt   = 1'b1;
                set_fault = 1'b1;
            end else begin
                next_pc = redirect_pc;
            end
        end else if (!stall) begin
            if (inc_over) begin
                go_halt   = 1'b1;
                set_fault = 1'b1;
            end else begin
                next_pc = inc_wide[31:0];
            end
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: loads a program into instruction memory, then streams
// sequential fetch addresses with stall/redirect/halt control and a sticky
// fault flag for out-of-range accesses.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int          INSTR_DEPTH = 1024,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_controller_if.slave bus
);

    // One extra bit so the pointer can hold INSTR_DEPTH (memory full).
    localparam int             PTR_W    = word_addr_w(INSTR_DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(INSTR_DEPTH);

    fetch_state_t     state, state_next;
    logic [PTR_W-1:0] load_ptr, load_ptr_next;
    logic [31:0]      pc_q, pc_next;
    logic             fault_q, fault_next;

    logic [31:0]      sel_pc;
    logic             sel_halt;
    logic             sel_fault;

    logic [31:0]      imem_addr;
    logic             imem_we;
    logic             load_ready;
    logic             pc_valid;

    fetch_controller_pc_next_sel #(
        .INSTR_DEPTH (INSTR_DEPTH)
    ) u_pc_next_sel (
        .pc             (pc_q),
        .stall          (bus.stall),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .halt           (bus.halt),
        .next_pc        (sel_pc),
        .go_halt        (sel_halt),
        .set_fault      (sel_fault)
    );

    // State, loader pointer, PC and fault registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_LOAD;
            load_ptr <= '0;
            pc_q     <= RESET_PC;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_next;
            load_ptr <= load_ptr_next;
            pc_q     <= pc_next;
            fault_q  <= fault_next;
        end
    end

    // Next-state and output decode; outputs are gated while reset is held.
    always_comb begin
        state_next    = state;
        load_ptr_next = load_ptr;
        pc_next       = pc_q;
        fault_next    = fault_q;
        imem_we       = 1'b0;
        imem_addr     = pc_q;
        load_ready    = 1'b0;
        pc_valid      = 1'b0;
        unique case (state)
            ST_LOAD: begin
                load_ready = ~reset;
                imem_addr  = 32'(load_ptr) << 2;
                if (bus.load_valid && (load_ptr == PTR_FULL)) begin
                    fault_next = 1'b1;
                    state_next = ST_HALT;
                end else begin
                    if (bus.load_valid) begin
                        imem_we       = ~reset;
                        load_ptr_next = load_ptr + PTR_W'(1);
                    end
                    if (bus.load_done) begin
                        state_next = ST_RUN;
                        pc_next    = RESET_PC;
                    end
                end
            end
            ST_RUN: begin
                pc_valid = ~reset;
                pc_next  = sel_pc;
                if (sel_fault) fault_next = 1'b1;
                if (sel_halt)  state_next = ST_HALT;
            end
            default: begin
            end
        endcase
    end

    assign bus.imem_addr  = imem_addr;
    assign bus.imem_we    = imem_we;
    assign bus.imem_wdata = bus.load_data;
    assign bus.load_ready = load_ready;
    assign bus.pc         = pc_q;
    assign bus.pc_valid   = pc_valid;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios on a 1024-word and a 4-word
// instance, plus randomized traffic checked against a behavioural model.
module tb_fetch_controller;

    localparam int DEPTH_BIG   = 1024;
    localparam int DEPTH_SMALL = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [31:0] mem_b [DEPTH_BIG];

    // Behavioural model state: mode 0 = loading, 1 = running, 2 = halted.
    int          m_mode;
    int          m_ptr;
    logic [31:0] m_pc;
    logic        m_fault;

    fetch_controller_if bus_b ();
    fetch_controller_if bus_s ();

    fetch_controller #(
        .INSTR_DEPTH (DEPTH_BIG),
        .RESET_PC    (32'h0000_0000)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    fetch_controller #(
        .INSTR_DEPTH (DEPTH_SMALL),
        .RESET_PC    (32'h0000_0000)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;

    // Instruction memory image of the large instance.
    always @(posedge clk) begin
        if (bus_b.imem_we === 1'b1) mem_b[bus_b.imem_addr[11:2]] <= bus_b.imem_wdata;
    end

    task automatic drive_b(input logic lv, input logic [31:0] ld, input logic ldone,
                           input logic st, input logic rv, input logic [31:0] rpc, input logic h);
        bus_b.load_valid     = lv;
        bus_b.load_data      = ld;
        bus_b.load_done      = ldone;
        bus_b.stall          = st;
        bus_b.redirect_valid = rv;
        bus_b.redirect_pc    = rpc;
        bus_b.halt           = h;
    endtask

    task automatic drive_s(input logic lv, input logic [31:0] ld, input logic ldone,
                           input logic st, input logic rv, input logic [31:0] rpc, input logic h);
        bus_s.load_valid     = lv;
        bus_s.load_data      = ld;
        bus_s.load_done      = ldone;
        bus_s.stall          = st;
        bus_s.redirect_valid = rv;
        bus_s.redirect_pc    = rpc;
        bus_s.halt           = h;
    endtask

    task automatic idle_all();
        drive_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive_s(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Leaves both instances in the loading state at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Large instance running at pc=0 with idle inputs, at a falling edge.
    task automatic go_run_b();
        do_reset();
        drive_b(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        idle_all();
    endtask

    task automatic model_clock(input logic lv, input logic ldone, input logic st,
                               input logic rv, input logic [31:0] rpc, input logic h);
        case (m_mode)
            0: begin
                if (lv && m_ptr == DEPTH_BIG) begin
                    m_fault = 1'b1;
                    m_mode  = 2;
                end else begin
                    if (lv) m_ptr = m_ptr + 1;
                    if (ldone) begin
                        m_mode = 1;
                        m_pc   = 32'h0;
                    end
                end
            end
            1: begin
                if (h) begin
                    m_mode = 2;
                end else if (rv) begin
                    if ((rpc % 4) != 0 || (rpc / 4) >= DEPTH_BIG) begin
                        m_fault = 1'b1;
                        m_mode  = 2;
                    end else begin
                        m_pc = rpc;
                    end
                end else if (!st) begin
                    if ((m_pc / 4) + 1 >= DEPTH_BIG) begin
                        m_fault = 1'b1;
                        m_mode  = 2;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            default: begin
            end
        endcase
    endtask

    task automatic test_reset();
        idle_all();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus_b.pc !== 32'h0 || bus_b.pc_valid !== 1'b0 || bus_b.imem_we !== 1'b0 ||
            bus_b.fault !== 1'b0 || bus_b.load_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: pc=%h pc_valid=%b we=%b fault=%b ready=%b, required 0/0/0/0/0",
                     bus_b.pc, bus_b.pc_valid, bus_b.imem_we, bus_b.fault, bus_b.load_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus_b.load_ready !== 1'b1 || bus_b.pc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b pc_valid=%b, required 1/0", bus_b.load_ready, bus_b.pc_valid);
        end
        // Reset asserted between edges while running must act at once.
        go_run_b();
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus_b.pc !== 32'h0 || bus_b.pc_valid !== 1'b0 || bus_b.load_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async_run: pc=%h pc_valid=%b ready=%b, required 0/0/0",
                     bus_b.pc, bus_b.pc_valid, bus_b.load_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_run();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            tests_run++;
            if (bus_b.imem_we !== 1'b1 || bus_b.imem_addr !== 32'(i * 4) ||
                bus_b.imem_wdata !== 32'hA0 + 32'(i) || bus_b.load_ready !== 1'b1 || bus_b.pc_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_word%0d: we=%b addr=%h data=%h ready=%b pv=%b, required 1/%h/%h/1/0", i,
                         bus_b.imem_we, bus_b.imem_addr, bus_b.imem_wdata, bus_b.load_ready, bus_b.pc_valid,
                         32'(i * 4), 32'hA0 + 32'(i));
            end
            @(negedge clk);
        end
        drive_b(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        tests_run++;
        if (bus_b.imem_we !== 1'b0 || bus_b.pc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_done_cycle: we=%b pv=%b, required 0/0", bus_b.imem_we, bus_b.pc_valid);
        end
        @(negedge clk);
        idle_all();
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++;
            if (bus_b.pc !== 32'(k * 4) || bus_b.pc_valid !== 1'b1 || bus_b.imem_addr !== 32'(k * 4) ||
                bus_b.imem_we !== 1'b0 || mem_b[k] !== 32'hA0 + 32'(k)) begin
                tests_failed++;
                $display("FAIL run_seq%0d: pc=%h pv=%b addr=%h we=%b mem=%h, required %h/1/%h/0/%h", k,
                         bus_b.pc, bus_b.pc_valid, bus_b.imem_addr, bus_b.imem_we, mem_b[k],
                         32'(k * 4), 32'(k * 4), 32'hA0 + 32'(k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        go_run_b();
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (bus_b.pc !== 32'h8) begin
            tests_failed++;
            $display("FAIL stall_start: pc=%h, required 00000008", bus_b.pc);
        end
        for (int j = 0; j < 3; j++) begin
            drive_b(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            #1;
            tests_run++;
            if (bus_b.pc !== 32'h8 || bus_b.pc_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: pc=%h pv=%b, required 00000008/1", j, bus_b.pc, bus_b.pc_valid);
            end
        end
        idle_all();
        @(negedge clk);
        #1;
        tests_run++;
        if (bus_b.pc !== 32'hC) begin
            tests_failed++;
            $display("FAIL stall_release: pc=%h, required 0000000c", bus_b.pc);
        end
    endtask

    task automatic test_redirect_stall();
        go_run_b();
        @(negedge clk);
        #1;
        tests_run++;
        if (bus_b.pc !== 32'h4) begin
            tests_failed++;
            $display("FAIL redir_start: pc=%h, required 00000004", bus_b.pc);
        end
        drive_b(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
        @(negedge clk);
        idle_all();
        #1;
        tests_run++;
        if (bus_b.pc !== 32'h40 || bus_b.fault !== 1'b0 || bus_b.pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL redir_over_stall: pc=%h fault=%b pv=%b, required 00000040/0/1",
                     bus_b.pc, bus_b.fault, bus_b.pc_valid);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus_b.pc !== 32'h44) begin
            tests_failed++;
            $display("FAIL redir_step: pc=%h, required 00000044", bus_b.pc);
        end
    endtask

    task automatic test_bad_redirect();
        go_run_b();
        @(negedge clk);
        drive_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h42, 1'b0);
        @(negedge clk);
        idle_all();
        #1;
        tests_run++;
        if (bus_b.fault !== 1'b1 || bus_b.pc !== 32'h4 || bus_b.pc_valid !== 1'b0 || bus_b.load_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_redir: fault=%b pc=%h pv=%b ready=%b, required 1/00000004/0/0",
                     bus_b.fault, bus_b.pc, bus_b.pc_valid, bus_b.load_ready);
        end
        for (int j = 0; j < 4; j++) begin
            drive_b(1'b1, $urandom, 1'b1, 1'(j), 1'b1, 32'(j * 4), 1'(j));
            #1;
            tests_run++;
            if (bus_b.imem_we !== 1'b0 || bus_b.pc !== 32'h4 || bus_b.fault !== 1'b1 ||
                bus_b.pc_valid !== 1'b0 || bus_b.load_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL halt_ignores%0d: we=%b pc=%h fault=%b pv=%b ready=%b, required 0/00000004/1/0/0",
                         j, bus_b.imem_we, bus_b.pc, bus_b.fault, bus_b.pc_valid, bus_b.load_ready);
            end
            @(negedge clk);
        end
        go_run_b();
        drive_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1000, 1'b0);
        @(negedge clk);
        idle_all();
        #1;
        tests_run++;
        if (bus_b.fault !== 1'b1 || bus_b.pc !== 32'h0 || bus_b.pc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_redir: fault=%b pc=%h pv=%b, required 1/00000000/0",
                     bus_b.fault, bus_b.pc, bus_b.pc_valid);
        end
        go_run_b();
        drive_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFC, 1'b0);
        @(negedge clk);
        idle_all();
        #1;
        tests_run++;
        if (bus_b.fault !== 1'b0 || bus_b.pc !== 32'hFFC || bus_b.pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL top_word_redir: fault=%b pc=%h pv=%b, required 0/00000ffc/1",
                     bus_b.fault, bus_b.pc, bus_b.pc_valid);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus_b.fault !== 1'b1 || bus_b.pc !== 32'hFFC || bus_b.pc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL top_word_step: fault=%b pc=%h pv=%b, required 1/00000ffc/0",
                     bus_b.fault, bus_b.pc, bus_b.pc_valid);
        end
    endtask

    task automatic test_overflow_small();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_s(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            tests_run++;
            if (bus_s.imem_we !== (i < 4) || (i < 4 && bus_s.imem_addr !== 32'(i * 4)) || bus_s.fault !== 1'b0) begin
                tests_failed++;
                $display("FAIL small_load%0d: we=%b addr=%h fault=%b, required %b/%h/0", i,
                         bus_s.imem_we, bus_s.imem_addr, bus_s.fault, (i < 4), 32'(i * 4));
            end
            @(negedge clk);
        end
        drive_s(1'b1, 32'hBF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        tests_run++;
        if (bus_s.fault !== 1'b1 || bus_s.load_ready !== 1'b0 || bus_s.imem_we !== 1'b0 || bus_s.pc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL small_overflow: fault=%b ready=%b we=%b pv=%b, required 1/0/0/0",
                     bus_s.fault, bus_s.load_ready, bus_s.imem_we, bus_s.pc_valid);
        end
        do_reset();
        drive_s(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        idle_all();
        #1;
        tests_run++;
        if (bus_s.pc !== 32'h0 || bus_s.pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL small_run0: pc=%h pv=%b, required 00000000/1", bus_s.pc, bus_s.pc_valid);
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (bus_s.pc !== 32'(k * 4) || bus_s.fault !== 1'b0) begin
                tests_failed++;
                $display("FAIL small_run%0d: pc=%h fault=%b, required %h/0", k, bus_s.pc, bus_s.fault, 32'(k * 4));
            end
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus_s.fault !== 1'b1 || bus_s.pc !== 32'hC || bus_s.pc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL small_end: fault=%b pc=%h pv=%b, required 1/0000000c/0",
                     bus_s.fault, bus_s.pc, bus_s.pc_valid);
        end
    endtask

    task automatic test_reset_midload();
        mem_b[2] = 32'hDEAD_BEEF;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive_b(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
        end
        drive_b(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        tests_run++;
        if (bus_b.imem_we !== 1'b1 || bus_b.imem_addr !== 32'h8) begin
            tests_failed++;
            $display("FAIL midload_third: we=%b addr=%h, required 1/00000008", bus_b.imem_we, bus_b.imem_addr);
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus_b.imem_we !== 1'b0 || bus_b.load_ready !== 1'b0 || bus_b.pc_valid !== 1'b0 ||
            bus_b.fault !== 1'b0 || bus_b.imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL midload_reset: we=%b ready=%b pv=%b fault=%b addr=%h, required 0/0/0/0/00000000",
                     bus_b.imem_we, bus_b.load_ready, bus_b.pc_valid, bus_b.fault, bus_b.imem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_b(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        tests_run++;
        if (bus_b.imem_we !== 1'b1 || bus_b.imem_addr !== 32'h0 || mem_b[2] !== 32'hDEAD_BEEF ||
            mem_b[1] !== 32'hC1) begin
            tests_failed++;
            $display("FAIL midload_restart: we=%b addr=%h mem2=%h mem1=%h, required 1/00000000/deadbeef/000000c1",
                     bus_b.imem_we, bus_b.imem_addr, mem_b[2], mem_b[1]);
        end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_random();
        logic        lv, ldone, st, rv, h, exp_we;
        logic [31:0] ld, rpc;
        int          target, halted, sel;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            m_mode  = 0;
            m_ptr   = 0;
            m_pc    = 32'h0;
            m_fault = 1'b0;
            target  = $urandom_range(12, 0);
            halted  = 0;
            for (int c = 0; c < 300 && halted < 8; c++) begin
                lv    = ($urandom_range(3, 0) != 0);
                ld    = $urandom;
                ldone = (m_mode != 0) ? 1'($urandom_range(1, 0)) :
                        ((m_ptr >= target) && ($urandom_range(2, 0) == 0));
                st    = ($urandom_range(3, 0) == 0);
                rv    = ($urandom_range(7, 0) == 0);
                h     = ($urandom_range(49, 0) == 0);
                sel   = $urandom_range(99, 0);
                if (sel < 70)      rpc = 32'($urandom_range(DEPTH_BIG - 1, 0) * 4);
                else if (sel < 85) rpc = 32'hFF0 + 32'($urandom_range(3, 0) * 4);
                else               rpc = $urandom;
                drive_b(lv, ld, ldone, st, rv, rpc, h);
                #1;
                exp_we = (m_mode == 0) && lv && (m_ptr < DEPTH_BIG);
                tests_run++;
                if (bus_b.pc !== m_pc || bus_b.fault !== m_fault || bus_b.pc_valid !== (m_mode == 1) ||
                    bus_b.load_ready !== (m_mode == 0) || bus_b.imem_we !== exp_we) begin
                    tests_failed++;
                    $display("FAIL rand_r%0d_c%0d: pc=%h fault=%b pv=%b ready=%b we=%b, required %h/%b/%b/%b/%b",
                             r, c, bus_b.pc, bus_b.fault, bus_b.pc_valid, bus_b.load_ready, bus_b.imem_we,
                             m_pc, m_fault, (m_mode == 1), (m_mode == 0), exp_we);
                end
                if (m_mode != 2) begin
                    tests_run++;
                    if (bus_b.imem_addr !== ((m_mode == 0) ? 32'(m_ptr * 4) : m_pc) ||
                        (exp_we && bus_b.imem_wdata !== ld)) begin
                        tests_failed++;
                        $display("FAIL rand_addr_r%0d_c%0d: addr=%h data=%h, required %h/%h", r, c,
                                 bus_b.imem_addr, bus_b.imem_wdata,
                                 (m_mode == 0) ? 32'(m_ptr * 4) : m_pc, ld);
                    end
                end
                model_clock(lv, ldone, st, rv, rpc, h);
                if (m_mode == 2) halted++;
                @(negedge clk);
            end
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_stall();
        test_redirect_stall();
        test_bad_redirect();
        test_overflow_small();
        test_reset_midload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
